victim_cache_nway: RTL and testbench
====================================

Name: victim_cache_nway

Overview:
Fully associative, parametrised victim cache between the L1 data cache and physical memory.
- Holds ENTRIES lines evicted from L1, with true-LRU replacement.
- On an L1 miss it either swaps the requested line back from a victim entry or fetches it from pmem.
- Writes back a dirty victim entry before reusing its slot.
- Successor to the single-entry victim cache: adds depth, LRU, insert/swap address collision handling and optional performance counters.

Parameters:
ENTRIES, 4, number of victim lines (power of 2, 2..16)
ADDR_W, 16, byte address width
LINE_W, 128, line width in bits
OFFSET_W, 4, line offset bits; tag = address[ADDR_W-1:OFFSET_W]

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mem_read  in  1  L1 requests line at mem_address; held until mem_resp
mem_write  in  1  L1 supplies evicted line (d_mem_address, mem_wdata, l1_dirty); held until mem_resp
mem_address  in  ADDR_W  requested line address
d_mem_address  in  ADDR_W  evicted line address
mem_wdata  in  LINE_W  evicted line data
l1_dirty  in  1  evicted line dirty
mem_rdata  out  LINE_W  returned line, valid with mem_resp
dirty_out  out  1  returned line was dirty in victim cache (valid with mem_resp)
ld_from_vic  out  1  returned line came from a victim entry (valid with mem_resp)
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  line fetch request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_address  out  ADDR_W  line-aligned (offset bits zero)
pmem_wdata  out  LINE_W  writeback data
pmem_rdata  in  LINE_W  fetch data, valid with pmem_resp
pmem_resp  in  1  pmem completion
hit_count  out  16  hit counter (see Optional Feature)
miss_count  out  16  miss counter (see Optional Feature)

Behaviour:
- Reset: all valid/dirty bits cleared, LRU order = index order (entry 0 is LRU), state IDLE. All outputs 0. Reset mid-transaction aborts it: pmem_read/pmem_write low the cycle after reset, no mem_resp.
- Per entry: valid, dirty, tag, data. Lookup is combinational in IDLE; a hit requires valid and tag equality.
- Victim slot selection: lowest-index invalid entry; otherwise the LRU entry.
- Collision: if the d_mem_address tag already matches a valid entry, that entry is the slot. It is overwritten in place and its dirty bit OR'd with l1_dirty.
- States: IDLE, WB, FETCH, RESP.
- IDLE, no request: stay.
- IDLE, mem_read hit → RESP:
  - Register the hit entry's data and dirty into mem_rdata/dirty_out; ld_from_vic=1.
  - If mem_write is also asserted, the hit entry is overwritten by the evicted line (swap) and becomes MRU.
  - Otherwise the hit entry is invalidated.
- IDLE, mem_read miss:
  - → WB if mem_write is asserted and the victim slot is valid and dirty.
  - → FETCH otherwise. On this transition the evicted line (if mem_write) is inserted into the slot and becomes MRU.
- WB: pmem_write=1, pmem_address = {slot tag, 0}, pmem_wdata = slot data. On pmem_resp: insert evicted line into the slot, → FETCH.
- FETCH: pmem_read=1, pmem_address = {mem_address tag, 0}. On pmem_resp: latch pmem_rdata into mem_rdata, dirty_out=0, ld_from_vic=0, → RESP.
- IDLE, mem_write only (insert, no read):
  - → WB if the slot is valid and dirty; after pmem_resp insert the line and → RESP.
  - Otherwise insert immediately and → RESP.
- RESP: mem_resp=1 for exactly one cycle, → IDLE. A request still asserted in that cycle is not re-sampled; a new request is sampled in the following IDLE cycle.
- Hit latency: mem_resp in the 2nd cycle after the request is first seen. Miss latency: pmem latencies plus 2 cycles.
- LRU: an inserted or swapped entry becomes MRU. A hit-without-swap invalidates the entry and moves it to LRU.
- pmem_read and pmem_write are never asserted together.

Optional Feature:
Macro VC_PERF_CNT_EN.
- Defined: hit_count increments on each IDLE→RESP hit; miss_count increments on each mem_read miss. Both are 16-bit, saturate at 0xFFFF and are cleared by reset.
- Undefined: no counter logic is built; hit_count and miss_count are tied to 0.

Test Plan:
- Reset, then mem_read 0x1230 with no mem_write → pmem_read with pmem_address 0x1230; pmem_resp with data D → one mem_resp, mem_rdata=D, ld_from_vic=0, dirty_out=0.
- Insert 0x4000 (l1_dirty=1, data A), then mem_read 0x4000 with mem_write 0x5000 (data B) → mem_resp 2 cycles later, mem_rdata=A, dirty_out=1, ld_from_vic=1, no pmem activity; a subsequent read of 0x5000 hits with data B.
- ENTRIES=4: insert 0x0000–0x0030 dirty, touch 0x0000 by swap, then miss on 0x0100 with eviction of 0x0200 → pmem_write of 0x0010 (LRU) precedes pmem_read of 0x0100.
- Insert 0x2000 clean, then insert 0x2000 again dirty with new data → single entry, dirty=1, new data returned on the next hit.
- Assert reset while in FETCH with pmem_read high → pmem_read=0 next cycle, no mem_resp, all entries invalid afterwards.
- With VC_PERF_CNT_EN: 3 hits and 2 misses → hit_count=3, miss_count=2. Without the macro → both 0.

Source files
------------

// File: rtl/victim_cache_nway.sv
// Fully associative victim cache with true-LRU replacement between L1 and physical memory.
// Optional feature macro VC_PERF_CNT_EN builds saturating hit/miss counters; otherwise they read 0.
module victim_cache_nway #(
    parameter int ENTRIES  = 4,
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    input  logic              l1_dirty,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              dirty_out,
    output logic              ld_from_vic,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, WB, FETCH, RESP} state_t;
    state_t state;

    logic [ENTRIES-1:0] valid, dirty;
    logic [TAG_W-1:0]   tags [ENTRIES];
    logic [LINE_W-1:0]  data [ENTRIES];
    // rank 0 is LRU, ENTRIES-1 is MRU; ranks always form a permutation
    logic [IDX_W-1:0]   rank [ENTRIES];

    logic [TAG_W-1:0]  rd_tag, d_tag;
    logic              unused_offset;
    assign rd_tag = mem_address[ADDR_W-1:OFFSET_W];
    assign d_tag  = d_mem_address[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^{mem_address[OFFSET_W-1:0], d_mem_address[OFFSET_W-1:0]};

    // Transaction context captured when leaving IDLE
    logic [IDX_W-1:0]  slot;
    logic [TAG_W-1:0]  lat_tag, req_tag;
    logic [LINE_W-1:0] lat_line;
    logic              lat_dirty, rd_pend;

    logic             hit, coll, has_free, need_wb;
    logic [IDX_W-1:0] hit_idx, coll_idx, free_idx, lru_idx, sel_idx;

    always_comb begin
        hit = 1'b0; hit_idx = '0;
        coll = 1'b0; coll_idx = '0;
        has_free = 1'b0; free_idx = '0;
        lru_idx = '0;
        // descending scan so the lowest matching index wins
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == rd_tag) begin hit = 1'b1; hit_idx = IDX_W'(i); end
            if (valid[i] && tags[i] == d_tag) begin coll = 1'b1; coll_idx = IDX_W'(i); end
            if (!valid[i]) begin has_free = 1'b1; free_idx = IDX_W'(i); end
            if (rank[i] == '0) lru_idx = IDX_W'(i);
        end
        sel_idx = coll ? coll_idx : (has_free ? free_idx : lru_idx);
        // a colliding entry is the same line, so it is merged rather than written back
        need_wb = !coll && valid[sel_idx] && dirty[sel_idx];
    end

    logic              do_ins, do_inv, ins_merge, ins_dirty;
    logic [IDX_W-1:0]  ins_at;
    logic [TAG_W-1:0]  ins_tag;
    logic [LINE_W-1:0] ins_line;

    always_comb begin
        do_ins = 1'b0; do_inv = 1'b0; ins_merge = 1'b0;
        ins_at = sel_idx; ins_tag = d_tag; ins_line = mem_wdata; ins_dirty = l1_dirty;
        case (state)
            IDLE: begin
                if (mem_read && hit) begin
                    if (mem_write) begin
                        do_ins = 1'b1;
                        ins_at = hit_idx;
                    end else begin
                        do_inv = 1'b1;
                    end
                end else if (mem_write && !need_wb) begin
                    do_ins    = 1'b1;
                    ins_merge = coll;
                end
            end
            WB: if (pmem_resp) begin
                do_ins = 1'b1; ins_at = slot; ins_tag = lat_tag;
                ins_line = lat_line; ins_dirty = lat_dirty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < ENTRIES; i++) rank[i] <= IDX_W'(i);
        end else if (do_ins) begin
            valid[ins_at] <= 1'b1;
            dirty[ins_at] <= ins_dirty | (ins_merge & dirty[ins_at]);
            tags[ins_at]  <= ins_tag;
            data[ins_at]  <= ins_line;
            for (int i = 0; i < ENTRIES; i++)
                if (rank[i] > rank[ins_at]) rank[i] <= rank[i] - 1'b1;
            rank[ins_at] <= IDX_W'(ENTRIES - 1);
        end else if (do_inv) begin
            valid[hit_idx] <= 1'b0;
            dirty[hit_idx] <= 1'b0;
            for (int i = 0; i < ENTRIES; i++)
                if (rank[i] < rank[hit_idx]) rank[i] <= rank[i] + 1'b1;
            rank[hit_idx] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mem_rdata <= '0; dirty_out <= 1'b0; ld_from_vic <= 1'b0; mem_resp <= 1'b0;
            pmem_read <= 1'b0; pmem_write <= 1'b0; pmem_address <= '0; pmem_wdata <= '0;
            slot <= '0; lat_tag <= '0; req_tag <= '0; lat_line <= '0;
            lat_dirty <= 1'b0; rd_pend <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read && hit) begin
                        mem_rdata   <= data[hit_idx];
                        dirty_out   <= dirty[hit_idx];
                        ld_from_vic <= 1'b1;
                        mem_resp    <= 1'b1;
                        state       <= RESP;
                    end else if (mem_read || mem_write) begin
                        slot <= sel_idx; lat_tag <= d_tag; lat_line <= mem_wdata;
                        lat_dirty <= l1_dirty; rd_pend <= mem_read; req_tag <= rd_tag;
                        if (mem_write && need_wb) begin
                            pmem_write   <= 1'b1;
                            pmem_address <= {tags[sel_idx], {OFFSET_W{1'b0}}};
                            pmem_wdata   <= data[sel_idx];
                            state        <= WB;
                        end else if (mem_read) begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {rd_tag, {OFFSET_W{1'b0}}};
                            state        <= FETCH;
                        end else begin
                            dirty_out <= 1'b0; ld_from_vic <= 1'b0; mem_resp <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WB: if (pmem_resp) begin
                    pmem_write <= 1'b0;
                    if (rd_pend) begin
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, {OFFSET_W{1'b0}}};
                        state        <= FETCH;
                    end else begin
                        dirty_out <= 1'b0; ld_from_vic <= 1'b0; mem_resp <= 1'b1;
                        state     <= RESP;
                    end
                end
                FETCH: if (pmem_resp) begin
                    pmem_read   <= 1'b0;
                    mem_rdata   <= pmem_rdata;
                    dirty_out   <= 1'b0;
                    ld_from_vic <= 1'b0;
                    mem_resp    <= 1'b1;
                    state       <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VC_PERF_CNT_EN
    logic hit_evt, miss_evt;
    assign hit_evt  = (state == IDLE) && mem_read && hit;
    assign miss_evt = (state == IDLE) && mem_read && !hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
            if (miss_evt && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_victim_cache_nway.sv
// Randomized scoreboard bench for victim_cache_nway against a queue/array cache model.
module tb_victim_cache_nway;
    localparam int NE = 4, AW = 16, LW = 128, OW = 4, TW = AW - OW;

    logic          clk = 1'b0, reset = 1'b1;
    logic          mem_read = 1'b0, mem_write = 1'b0, l1_dirty = 1'b0;
    logic [AW-1:0] mem_address = '0, d_mem_address = '0;
    logic [LW-1:0] mem_wdata = '0;
    logic [LW-1:0] mem_rdata, pmem_wdata;
    logic          dirty_out, ld_from_vic, mem_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic [15:0]   hit_count, miss_count;

    victim_cache_nway #(.ENTRIES(NE), .ADDR_W(AW), .LINE_W(LW), .OFFSET_W(OW)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .d_mem_address(d_mem_address), .mem_wdata(mem_wdata),
        .l1_dirty(l1_dirty), .mem_rdata(mem_rdata), .dirty_out(dirty_out),
        .ld_from_vic(ld_from_vic), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { bit rd; bit hit; bit vic; bit dirty; logic [LW-1:0] rdata; int cyc; } exp_t;
    typedef struct { bit wr; logic [AW-1:0] addr; logic [LW-1:0] data; } pop_t;

    exp_t scb[$];
    pop_t pexp[$];
    pop_t plog[$];
    int n_chk = 0, n_fail = 0;
    bit pmem_stall = 1'b0;
    logic [LW-1:0] last_rdata;
    bit last_vic, last_dirty;

    // Reference cache: per-slot arrays plus an LRU-ordered index queue (front = LRU)
    bit            m_valid [NE];
    bit            m_dirty [NE];
    logic [TW-1:0] m_tag   [NE];
    logic [LW-1:0] m_data  [NE];
    int            lru_q[$];
    logic [LW-1:0] mmem[int];
    logic [LW-1:0] parr[int];
    int            m_hits, m_miss;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] init_line(input logic [TW-1:0] t);
        return {32'(t) * 32'h9E3779B1, 32'(t) + 32'hC0DE0000, ~32'(t), 32'(t) ^ 32'h5A5A5A5A};
    endfunction

    function automatic int find(input logic [TW-1:0] t);
        for (int i = 0; i < NE; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    task automatic move(input int k, input bit to_lru);
        for (int i = 0; i < lru_q.size(); i++)
            if (lru_q[i] == k) begin lru_q.delete(i); break; end
        if (to_lru) lru_q.push_front(k); else lru_q.push_back(k);
    endtask

    task automatic model_reset();
        lru_q.delete();
        for (int i = 0; i < NE; i++) begin m_valid[i] = 0; m_dirty[i] = 0; lru_q.push_back(i); end
        m_hits = 0; m_miss = 0;
    endtask

    task automatic model_txn(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] da,
                             input logic [LW-1:0] wd, input bit ld, output exp_t e);
        int h, s; pop_t p; logic [TW-1:0] t, dt;
        t = a[AW-1:OW]; dt = da[AW-1:OW];
        e.rd = rd; e.hit = 0; e.vic = 0; e.dirty = 0; e.rdata = '0; e.cyc = 0;
        h = find(t);
        if (rd && h >= 0) begin
            e.hit = 1; e.vic = 1; e.dirty = m_dirty[h]; e.rdata = m_data[h]; m_hits++;
            if (wr) begin
                m_tag[h] = dt; m_data[h] = wd; m_dirty[h] = ld; move(h, 0);
            end else begin
                m_valid[h] = 0; m_dirty[h] = 0; move(h, 1);
            end
        end else begin
            if (rd) m_miss++;
            if (wr) begin
                s = find(dt);
                if (s >= 0) m_dirty[s] = m_dirty[s] | ld;
                else begin
                    for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) s = i;
                    if (s < 0) s = lru_q[0];
                    if (m_valid[s] && m_dirty[s]) begin
                        p.wr = 1; p.addr = {m_tag[s], 4'h0}; p.data = m_data[s];
                        pexp.push_back(p);
                        mmem[int'(m_tag[s])] = m_data[s];
                    end
                    m_dirty[s] = ld;
                end
                m_valid[s] = 1; m_tag[s] = dt; m_data[s] = wd; move(s, 0);
            end
            if (rd) begin
                p.wr = 0; p.addr = {t, 4'h0}; p.data = '0;
                pexp.push_back(p);
                e.rdata = mmem.exists(int'(t)) ? mmem[int'(t)] : init_line(t);
            end
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT completes
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_resp) begin
            if (scb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL mem_resp_unexpected: got mem_resp=1, expected no response");
            end else begin
                e = scb.pop_front();
                if (e.rd) begin
                    chk("mem_rdata", mem_rdata, e.rdata);
                    chk("ld_from_vic", LW'(ld_from_vic), LW'(e.vic));
                    chk("dirty_out", LW'(dirty_out), LW'(e.dirty));
                end
                if (e.hit) chk("hit_latency_cycle", LW'(cyc), LW'(e.cyc));
            end
            last_rdata = mem_rdata; last_vic = ld_from_vic; last_dirty = dirty_out;
        end
    end

    // Physical memory: random latency, checks each request against the model's expected op list
    initial begin : pmem_model
        bit busy; int left; pop_t x, ex; logic [TW-1:0] t;
        busy = 0; left = 0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 0; busy = 0;
            end else if (!(pmem_read || pmem_write)) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1; left = $urandom_range(0, 3);
                    chk("pmem_rd_wr_exclusive", LW'(pmem_read & pmem_write), '0);
                    x.wr = pmem_write; x.addr = pmem_address; x.data = pmem_wdata;
                    plog.push_back(x);
                    if (pexp.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL pmem_unexpected: got wr=%0d addr=%h, expected no pmem op", x.wr, x.addr);
                    end else begin
                        ex = pexp.pop_front();
                        chk("pmem_op_is_write", LW'(x.wr), LW'(ex.wr));
                        chk("pmem_address", LW'(x.addr), LW'(ex.addr));
                        if (ex.wr) chk("pmem_wdata", x.data, ex.data);
                    end
                end
                if (!pmem_stall) begin
                    if (left == 0) begin
                        t = pmem_address[AW-1:OW];
                        if (pmem_write) parr[int'(t)] = pmem_wdata;
                        else pmem_rdata = parr.exists(int'(t)) ? parr[int'(t)] : init_line(t);
                        pmem_resp = 1;
                    end else left--;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1; mem_read = 0; mem_write = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset(); scb.delete(); pexp.delete();
        @(negedge clk);
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] da,
                          input logic [LW-1:0] wd, input bit ld);
        exp_t e; bit got;
        model_txn(rd, wr, a, da, wd, ld, e);
        e.cyc = cyc + 1;
        scb.push_back(e);
        mem_read = rd; mem_write = wr; mem_address = a; d_mem_address = da;
        mem_wdata = wd; l1_dirty = ld;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_resp) begin got = 1; break; end
        end
        mem_read = 0; mem_write = 0;
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout: got no mem_resp, expected one for addr %h", a);
            do_reset();
        end
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        chk("pmem_ops_outstanding", LW'(pexp.size()), '0);
    endtask

    task automatic rand_txn();
        int k, tries; bit rd, wr; logic [TW-1:0] t, dt;
        k = $urandom_range(0, 2);
        rd = (k != 2); wr = (k != 0);
        t  = 12'h800 + 12'($urandom_range(0, 11));
        dt = 12'h800 + 12'($urandom_range(0, 11));
        if (rd && wr) begin
            tries = 0;
            while ((dt == t || (find(t) >= 0 && find(dt) >= 0)) && tries < 50) begin
                dt = 12'h800 + 12'($urandom_range(0, 11)); tries++;
            end
            if (dt == t || (find(t) >= 0 && find(dt) >= 0)) wr = 0;
        end
        do_txn(rd, wr, {t, 4'($urandom_range(0, 15))}, {dt, 4'($urandom_range(0, 15))},
               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [LW-1:0] la, lb, lx, ly;
        logic [15:0] exp_h, exp_m;
        bit got;
        la = {4{32'hAAAA_0001}}; lb = {4{32'hBBBB_0002}};
        lx = {4{32'h1111_2222}}; ly = {4{32'h3333_4444}};

        do_reset();
        chk("rst_mem_resp", LW'(mem_resp), '0);
        chk("rst_pmem_read", LW'(pmem_read), '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_pmem_address", LW'(pmem_address), '0);
        chk("rst_mem_rdata", mem_rdata, '0);
        chk("rst_flags", LW'({dirty_out, ld_from_vic}), '0);
        chk("rst_counters", LW'({hit_count, miss_count}), '0);

        // Cold miss fetched from pmem
        do_txn(1, 0, 16'h1230, 16'h0000, '0, 0);
        chk("t1_rdata", last_rdata, init_line(12'h123));
        chk("t1_vic", LW'(last_vic), '0);

        // Insert then swap on hit; no pmem traffic on the hit
        do_txn(0, 1, 16'h0000, 16'h4000, la, 1);
        plog.delete();
        do_txn(1, 1, 16'h4000, 16'h5000, lb, 0);
        chk("t2_rdata", last_rdata, la);
        chk("t2_dirty", LW'(last_dirty), LW'(1));
        chk("t2_vic", LW'(last_vic), LW'(1));
        chk("t2_no_pmem", LW'(plog.size()), '0);
        do_txn(1, 0, 16'h5000, 16'h0000, '0, 0);
        chk("t2_swapped_in", last_rdata, lb);

        // LRU victim writeback before fetch
        do_reset();
        for (int i = 0; i < 4; i++) do_txn(0, 1, 16'h0000, AW'(i * 16), {4{32'(i)}}, 1);
        do_txn(1, 1, 16'h0000, 16'h0040, lx, 1);
        plog.delete();
        do_txn(1, 1, 16'h0100, 16'h0200, ly, 0);
        chk("t3_pmem_op_count", LW'(plog.size()), LW'(2));
        if (plog.size() == 2) begin
            chk("t3_first_is_wb", LW'(plog[0].wr), LW'(1));
            chk("t3_wb_addr", LW'(plog[0].addr), LW'(16'h0010));
            chk("t3_second_is_fetch", LW'(plog[1].wr), '0);
            chk("t3_fetch_addr", LW'(plog[1].addr), LW'(16'h0100));
        end

        // Re-insert of a resident line merges in place
        do_txn(0, 1, 16'h0000, 16'h2000, lx, 0);
        do_txn(0, 1, 16'h0000, 16'h2000, ly, 1);
        do_txn(1, 0, 16'h2000, 16'h0000, '0, 0);
        chk("t4_rdata", last_rdata, ly);
        chk("t4_dirty", LW'(last_dirty), LW'(1));
        do_txn(1, 0, 16'h2000, 16'h0000, '0, 0);
        chk("t4_single_entry", LW'(last_vic), '0);

        for (int n = 0; n < 300; n++) rand_txn();
`ifdef VC_PERF_CNT_EN
        exp_h = 16'(m_hits); exp_m = 16'(m_miss);
`else
        exp_h = 16'h0; exp_m = 16'h0;
`endif
        chk("rand_hit_count", LW'(hit_count), LW'(exp_h));
        chk("rand_miss_count", LW'(miss_count), LW'(exp_m));

        // Reset while a fetch is outstanding
        do_reset();
        do_txn(0, 1, 16'h0000, 16'h6000, lx, 1);
        begin
            pop_t p;
            p.wr = 0; p.addr = 16'h3330; p.data = '0;
            pexp.push_back(p);
        end
        pmem_stall = 1;
        mem_read = 1; mem_address = 16'h3330;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pmem_read) begin got = 1; break; end
        end
        chk("t5_fetch_started", LW'(got), LW'(1));
        reset = 1;
        @(negedge clk);
        chk("t5_pmem_read_dropped", LW'(pmem_read), '0);
        chk("t5_no_resp", LW'(mem_resp), '0);
        mem_read = 0;
        @(negedge clk);
        reset = 0;
        model_reset(); scb.delete(); pexp.delete();
        pmem_stall = 0;
        @(negedge clk);
        do_txn(1, 0, 16'h6000, 16'h0000, '0, 0);
        chk("t5_entries_cleared", LW'(last_vic), '0);

        // Counter scenario: 3 hits, 2 misses
        do_reset();
        for (int i = 0; i < 3; i++) do_txn(0, 1, 16'h0000, 16'h7000 + AW'(i * 16), {4{32'(i + 7)}}, 0);
        for (int i = 0; i < 3; i++) do_txn(1, 0, 16'h7000 + AW'(i * 16), 16'h0000, '0, 0);
        do_txn(1, 0, 16'h7100, 16'h0000, '0, 0);
        do_txn(1, 0, 16'h7110, 16'h0000, '0, 0);
`ifdef VC_PERF_CNT_EN
        exp_h = 16'd3; exp_m = 16'd2;
`else
        exp_h = 16'd0; exp_m = 16'd0;
`endif
        chk("t6_hit_count", LW'(hit_count), LW'(exp_h));
        chk("t6_miss_count", LW'(miss_count), LW'(exp_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
